rv32m_div_sequencer: RTL and testbench

Multi-cycle sequencer for the RV32M divide/remainder instructions: DIV, DIVU, REM and REMU.
- Sits beside the EX-stage ALU.
- Accepts one operation from the decoder/controller and runs a radix-2 restoring divide over XLEN iterations.
- Asserts a pipeline stall until the result is ready.
- Resolves RISC-V special cases (divide-by-zero, signed overflow) without iterating.

---
 rtl/rv32m_pkg.sv | 39 +++
 rtl/rv32m_div_step.sv | 37 +++
 rtl/rv32m_div_sequencer.sv | 179 +++++++++++++++++
 tb/tb_rv32m_div_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32m_pkg.sv
// ---------------------------------------------------------------------------
// rv32m_pkg
// Shared definitions for the RV32M divide sequencer: funct3 encodings,
// divider FSM state type and default datapath widths.
// ---------------------------------------------------------------------------
package rv32m_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int CNT_W_DEFAULT = $clog2(XLEN_DEFAULT);

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ADJ  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // All four divide/remainder codes share funct3[2]=1; the rest of the
  // OP funct3 space belongs to the multiplier and is ignored here.
  function automatic logic f3_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // funct3[0]=0 selects the signed variants (DIV/REM).
  function automatic logic f3_is_signed(input logic [2:0] f3);
    return ~f3[0];
  endfunction

  // funct3[1]=1 selects the remainder variants (REM/REMU).
  function automatic logic f3_is_rem(input logic [2:0] f3);
    return f3[1];
  endfunction

endpackage

// File: rtl/rv32m_div_step.sv
// ---------------------------------------------------------------------------
// rv32m_div_step
// One combinational radix-2 restoring divide step.
//   rem      : partial remainder (XLEN+1 bits, top bit kept for the borrow)
//   quo      : partial quotient / remaining dividend bits
//   divisor  : magnitude of the divisor
//   rem_next : partial remainder after the shift/trial-subtract
//   quo_next : quotient after shifting in the new quotient bit
// ---------------------------------------------------------------------------
module rv32m_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next,
  output logic [XLEN-1:0] quo_next
);

  // One guard bit above the shifted remainder so the sign of the trial
  // subtraction is unambiguous for any divisor up to 2^XLEN-1.
  logic [XLEN+1:0] rem_sh;
  logic [XLEN+1:0] trial;

  always_comb begin
    rem_sh = {rem, quo[XLEN-1]};
    trial  = rem_sh - {2'b00, divisor};
    if (!trial[XLEN+1]) begin
      rem_next = trial[XLEN:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_next = rem_sh[XLEN:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/rv32m_div_sequencer.sv
// ---------------------------------------------------------------------------
// rv32m_div_sequencer
// Multi-cycle DIV/DIVU/REM/REMU unit beside the EX-stage ALU. Runs XLEN
// restoring iterations on operand magnitudes, fixes signs in one extra
// cycle, and resolves divide-by-zero / signed overflow without iterating.
//   clk, nrst : clock (rising edge), async active-low reset
//   start     : divide op valid (only looked at in IDLE)
//   funct3    : 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   op_a/op_b : dividend / divisor, sampled with an accepted start
//   flush     : abort an op in CALC/ADJ; blocks acceptance in IDLE
//   stall     : hold IF/ID/EX while the op is in flight
//   busy      : FSM not idle
//   done      : one-cycle result-valid pulse
//   result    : quotient or remainder, held until the next accepted op
// ---------------------------------------------------------------------------
module rv32m_div_sequencer
  import rv32m_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [XLEN:0]    rem;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  divisor;
  logic [XLEN-1:0]  result_q;
  logic             is_rem;
  logic             neg_q;
  logic             neg_r;

  logic [XLEN:0]    rem_next;
  logic [XLEN-1:0]  quo_next;

  // Decode of the request as presented in IDLE.
  logic            req_ok;
  logic            accept;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            div_zero;
  logic            ovf;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] adj_res;

  assign req_ok   = start & f3_is_div(funct3);
  assign accept   = (state == IDLE) & req_ok & ~flush;

  assign a_neg    = f3_is_signed(funct3) & op_a[XLEN-1];
  assign b_neg    = f3_is_signed(funct3) & op_b[XLEN-1];
  assign abs_a    = a_neg ? (~op_a + 1'b1) : op_a;
  assign abs_b    = b_neg ? (~op_b + 1'b1) : op_b;

  assign div_zero = (op_b == '0);
  assign ovf      = f3_is_signed(funct3) & (op_a == MIN_INT) & (op_b == '1);
  assign special  = div_zero | ovf;

  // Architectural results for the cases that skip the iteration.
  always_comb begin
    special_res = '0;
    if (div_zero) special_res = f3_is_rem(funct3) ? op_a : '1;
    else          special_res = f3_is_rem(funct3) ? '0   : MIN_INT;
  end

  // Sign fix-up: quotient negative iff operand signs differ, remainder
  // takes the sign of the dividend. neg_* are already zero for unsigned ops.
  always_comb begin
    adj_res = '0;
    if (is_rem) adj_res = neg_r ? (~rem[XLEN-1:0] + 1'b1) : rem[XLEN-1:0];
    else        adj_res = neg_q ? (~quo + 1'b1) : quo;
  end

  rv32m_div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_next;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = special ? DONE : CALC;
      CALC: begin
        if (flush)           state_next = IDLE;
        else if (cnt == '0)  state_next = ADJ;
      end
      ADJ:  state_next = flush ? IDLE : DONE;
      // A flush here is deliberately ignored: the result is already
      // committed and the pipeline is consuming it this cycle.
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    stall = 1'b0;
    busy  = 1'b1;
    done  = 1'b0;
    unique case (state)
      IDLE: begin
        busy  = 1'b0;
        stall = req_ok & ~flush;
      end
      CALC: stall = 1'b1;
      ADJ:  stall = 1'b1;
      DONE: done  = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // ---- Datapath ----
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      result_q <= '0;
      is_rem   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            is_rem  <= f3_is_rem(funct3);
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            rem     <= '0;
            quo     <= abs_a;
            divisor <= abs_b;
            cnt     <= CNT_W'(XLEN - 1);
            if (special) result_q <= special_res;
          end
        end
        CALC: begin
          rem <= rem_next;
          quo <= quo_next;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        ADJ: begin
          if (!flush) result_q <= adj_res;
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_rv32m_div_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rv32m_div_sequencer
// Directed bench for the RV32M divide sequencer. A transaction-level model
// (plain integer division plus a latency count) predicts stall/busy/done/
// result every cycle; directed ops also pin results and latencies to
// hand-computed literals.
// ---------------------------------------------------------------------------
module tb_rv32m_div_sequencer;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  localparam logic [2:0] DIV  = 3'b100;
  localparam logic [2:0] DIVU = 3'b101;
  localparam logic [2:0] REM  = 3'b110;
  localparam logic [2:0] REMU = 3'b111;

  rv32m_div_sequencer dut (
    .clk    (clk),
    .nrst   (nrst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return f[1] ? 32'd0 : 32'h8000_0000;
    if (!f[0]) begin
      // SV integer / and % truncate toward zero, same as RISC-V.
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return f[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return f[1] ? 32'(ua % ub) : 32'(ua / ub);
  endfunction

  // m_ticks counts cycles since acceptance; done is due when it reaches
  // m_lat (1 for special cases, XLEN+2 otherwise).
  bit          m_act = 1'b0;
  int          m_ticks = 0;
  int          m_lat = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_result = '0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_act    <= 1'b0;
      m_ticks  <= 0;
      m_result <= '0;
    end else if (m_act) begin
      if (m_ticks == m_lat)  m_act <= 1'b0;
      else if (flush)        m_act <= 1'b0;
      else begin
        m_ticks <= m_ticks + 1;
        if (m_ticks + 1 == m_lat) m_result <= m_pend;
      end
    end else if (start && funct3[2] && !flush) begin
      m_act   <= 1'b1;
      m_ticks <= 1;
      m_pend  <= model_res(funct3, op_a, op_b);
      m_lat   <= is_special(funct3, op_a, op_b) ? 1 : 34;
      if (is_special(funct3, op_a, op_b)) m_result <= model_res(funct3, op_a, op_b);
    end
  end

  // Per-cycle compare, half a period away from the active edge.
  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = (m_act && m_ticks < m_lat) || (!m_act && start && funct3[2] && !flush);
    chk("stall",  32'(stall), 32'(exp_stall));
    chk("busy",   32'(busy),  32'(m_act));
    chk("done",   32'(done),  32'(m_act && m_ticks == m_lat));
    chk("result", result, m_result);
  end

  // ---------------- directed stimulus ----------------
  // Issues one op, optionally pokes a second start at cycle 'poke' while
  // busy, and pins latency and result to hand-computed literals.
  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lit, input int lat,
                        input int poke);
    int cyc;
    @(posedge clk); #1;
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == poke) begin
        start = 1'b1; funct3 = DIVU; op_a = 32'd50; op_b = 32'd5;
      end else begin
        start = 1'b0;
      end
    end
    chk({nm, "_latency"}, 32'(cyc), 32'(lat));
    chk({nm, "_result"}, result, lit);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", result, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    nrst = 1'b1;

    run_op("div_neg7_2",   DIV,  32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFD, 34, 0);
    run_op("rem_neg7_2",   REM,  32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFF, 34, 0);
    run_op("divu_max_16",  DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 34, 0);
    run_op("remu_max_16",  REMU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 34, 0);
    run_op("div_by0",      DIV,  32'd5,         32'd0,  32'hFFFF_FFFF, 1,  0);
    run_op("rem_by0",      REM,  32'h1234,      32'd0,  32'h0000_1234, 1,  0);
    run_op("divu_by0",     DIVU, 32'd77,        32'd0,  32'hFFFF_FFFF, 1,  0);
    run_op("div_ovf",      DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ovf",      REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
    // Unsigned op with the same bit patterns is an ordinary divide.
    run_op("divu_minint",  DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, 0);
    run_op("div_100_neg7", DIV,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 34, 0);
    run_op("rem_100_neg7", REM,  32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 34, 0);

    // Flush in cycle 10 of DIVU 100/7: idle in cycle 11, result keeps 2.
    @(posedge clk); #1;
    start = 1'b1; funct3 = DIVU; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy",   32'(busy),  32'd0);
    chk("flush_stall",  32'(stall), 32'd0);
    chk("flush_done",   32'(done),  32'd0);
    chk("flush_result", result, 32'd2);
    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 34, 0);

    // start together with flush in IDLE is not accepted.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; funct3 = DIV; op_a = 32'd9; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("startflush_busy", 32'(busy), 32'd0);

    // Non-divide funct3 is ignored.
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b000; op_a = 32'd9; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    chk("badf3_busy", 32'(busy), 32'd0);

    // Flush during DONE: the pulse still happens.
    @(posedge clk); #1;
    start = 1'b1; funct3 = DIV; op_a = 32'd1; op_b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b1;
    chk("flushdone_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flushdone_idle", 32'(busy), 32'd0);

    // Reset during CALC: outputs drop immediately.
    @(posedge clk); #1;
    start = 1'b1; funct3 = DIV; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    nrst = 1'b0;
    #1;
    chk("rst_busy",   32'(busy),  32'd0);
    chk("rst_stall",  32'(stall), 32'd0);
    chk("rst_done",   32'(done),  32'd0);
    chk("rst_result", result, 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;

    // start while busy is ignored; original op completes.
    run_op("div_poke", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 5);
    run_op("div_1000_3", DIV, 32'd1000, 32'd3, 32'd333, 34, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
